// File: rtl/rx_if.sv
// Receiver bus bundle: baud enable, control/config, serial line and frame results.
interface rx_if #(
  parameter int MAX_DATA_WIDTH = 8
) ();
  logic                      baud_en_i;
  logic                      rx_en_i;
  logic [4:0]                rx_conf_i;
  logic                      uart_rx_i;
  logic [MAX_DATA_WIDTH-1:0] rx_data_o;
  logic                      rx_valid_o;
  logic                      rx_parity_err_o;
  logic                      rx_frame_err_o;
  logic                      rx_busy_o;

  // Driver side (register logic / pad / baud generator)
  modport master (
    output baud_en_i, rx_en_i, rx_conf_i, uart_rx_i,
    input  rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o
  );

  // Receiver side
  modport slave (
    input  baud_en_i, rx_en_i, rx_conf_i, uart_rx_i,
    output rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o
  );
endinterface

// File: rtl/rx_module.sv
// UART receive stage: 16x oversampled frame recovery with parity and stop-bit checking.
// Line polarity: idle 0, start 1, stop 0; data LSB first, optional even parity.
module rx_module #(
  parameter int MAX_DATA_WIDTH       = 8,
  parameter int SAMPLE_COUNTER_WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  rx_if.slave  bus
);

  localparam int DCW = $clog2(MAX_DATA_WIDTH);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // Counter value at the bit midpoint (start check) and at a full bit period (data/stop sampling)
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_HALF = SAMPLE_COUNTER_WIDTH'((1 << (SAMPLE_COUNTER_WIDTH-1)) - 1);
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_FULL = '1;

  typedef struct packed {
    logic [1:0] data_size;
    logic [1:0] stop_size;
    logic       parity_en;
  } rx_conf_t;

  logic [1:0]                      sync_q;
  logic                            rx_s;
  logic [2:0]                      state_q, state_d;
  logic [SAMPLE_COUNTER_WIDTH-1:0] scnt_q, scnt_d;
  logic [DCW-1:0]                  dcnt_q, dcnt_d;
  logic [1:0]                      stcnt_q, stcnt_d;
  rx_conf_t                        conf_q, conf_d;
  logic [MAX_DATA_WIDTH-1:0]       shf_q, shf_d;
  logic                            perr_q, perr_d;
  logic                            ferr_q, ferr_d;
  logic                            busy_q, busy_d;
  logic [MAX_DATA_WIDTH-1:0]       data_o_q, data_o_d;
  logic                            perr_o_q, perr_o_d;
  logic                            ferr_o_q, ferr_o_d;
  logic                            valid_q, valid_d;
  logic [DCW-1:0]                  last_bit;

  assign rx_s     = sync_q[1];
  assign last_bit = DCW'(32'd4 + 32'(conf_q.data_size));

  // Two-flop synchroniser on the asynchronous serial line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], bus.uart_rx_i};
  end

  // Next-state logic; everything except the valid pulse advances only on baud ticks
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    dcnt_d   = dcnt_q;
    stcnt_d  = stcnt_q;
    conf_d   = conf_q;
    shf_d    = shf_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    busy_d   = busy_q;
    data_o_d = data_o_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    valid_d  = 1'b0;
    if (bus.baud_en_i) begin
      if (!bus.rx_en_i && state_q != S_RESET && state_q != S_DONE) begin
        // Disable aborts the frame silently
        state_d = S_RESET;
        busy_d  = 1'b0;
      end else begin
        case (state_q)
          S_RESET: state_d = S_IDLE;
          S_IDLE: if (rx_s) begin
            state_d = S_START;
            scnt_d  = '0;
            conf_d  = rx_conf_t'(bus.rx_conf_i);
          end
          S_START: begin
            if (scnt_q == CNT_HALF) begin
              if (rx_s) begin
                state_d = S_DATA;
                scnt_d  = '0;
                dcnt_d  = '0;
                shf_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              scnt_d = scnt_q + 1'b1;
            end
          end
          S_DATA: begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == CNT_FULL) begin
              shf_d[dcnt_q] = rx_s;
              if (dcnt_q == last_bit) begin
                dcnt_d  = '0;
                stcnt_d = '0;
                state_d = conf_q.parity_en ? S_PARITY : S_STOP;
              end else begin
                dcnt_d = dcnt_q + 1'b1;
              end
            end
          end
          S_PARITY: begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == CNT_FULL) begin
              perr_d  = rx_s ^ (^shf_q);
              state_d = S_STOP;
            end
          end
          S_STOP: begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == CNT_FULL) begin
              ferr_d = ferr_q | rx_s;
              if (stcnt_q == conf_q.stop_size) state_d = S_DONE;
              else                             stcnt_d = stcnt_q + 1'b1;
            end
          end
          S_DONE: begin
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            data_o_d = shf_q;
            perr_o_d = perr_q;
            ferr_o_d = ferr_q;
            state_d  = bus.rx_en_i ? S_IDLE : S_RESET;
          end
          default: state_d = S_RESET;
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_RESET;
      scnt_q   <= '0;
      dcnt_q   <= '0;
      stcnt_q  <= '0;
      conf_q   <= '0;
      shf_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_o_q <= '0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      dcnt_q   <= dcnt_d;
      stcnt_q  <= stcnt_d;
      conf_q   <= conf_d;
      shf_q    <= shf_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      data_o_q <= data_o_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.rx_data_o       = data_o_q;
  assign bus.rx_valid_o      = valid_q;
  assign bus.rx_parity_err_o = perr_o_q;
  assign bus.rx_frame_err_o  = ferr_o_q;
  assign bus.rx_busy_o       = busy_q;

endmodule

// File: tb/tb_rx_module.sv
// Directed bench for rx_module: frame formats, parity/framing errors, glitch, abort, reset, back-to-back.
`timescale 1ns/1ps
module tb_rx_module;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   bdiv  = 0;
  int   nvalid = 0;
  bit   busy_seen = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_perr[$];
  logic       cap_ferr[$];

  rx_if #(.MAX_DATA_WIDTH(8)) bus ();

  rx_module #(.MAX_DATA_WIDTH(8), .SAMPLE_COUNTER_WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Baud tick every 4 clocks
  always @(posedge clk) begin
    bdiv <= (bdiv == 3) ? 0 : bdiv + 1;
    bus.baud_en_i <= (bdiv == 3);
  end

  // Capture every clock the valid pulse is high, so a stretched pulse shows up as an extra frame
  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1) begin
      nvalid++;
      cap_data.push_back(bus.rx_data_o);
      cap_perr.push_back(bus.rx_parity_err_o);
      cap_ferr.push_back(bus.rx_frame_err_o);
    end
    if (bus.rx_busy_o === 1'b1) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.baud_en_i !== 1'b1);
    end
  endtask

  task automatic line(input logic v, input int n);
    bus.uart_rx_i = v;
    ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_bit, input int nstop, input bit stop_v);
    line(1'b1, 16);
    for (int i = 0; i < nbits; i++) line(d[i], 16);
    if (par_en) line(par_bit, 16);
    for (int i = 0; i < nstop; i++) line(stop_v, 16);
    bus.uart_rx_i = 1'b0;
  endtask

  // Check one captured frame against expectations; n0 is the pulse count before the frame
  task automatic chk_frame(input string tag, input int n0, input logic [7:0] d,
                           input logic pe, input logic fe);
    chk({tag, ".cnt"}, nvalid - n0, 1);
    if (nvalid > n0) begin
      chk({tag, ".data"}, cap_data[n0], d);
      chk({tag, ".perr"}, cap_perr[n0], pe);
      chk({tag, ".ferr"}, cap_ferr[n0], fe);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.rx_en_i   = 1'b0;
    bus.rx_conf_i = 5'b11000;
    bus.uart_rx_i = 1'b0;
    #23;
    chk("rst.data",  bus.rx_data_o, 8'h00);
    chk("rst.valid", bus.rx_valid_o, 1'b0);
    chk("rst.busy",  bus.rx_busy_o, 1'b0);
    chk("rst.errs",  {bus.rx_parity_err_o, bus.rx_frame_err_o}, 2'b00);
    @(negedge clk) rst = 1'b0;
    bus.rx_en_i = 1'b1;
    ticks(4);

    // 8N1 0xA5
    n0 = nvalid;
    send_frame(8'hA5, 8, 0, 0, 1, 0);
    line(1'b0, 20);
    chk_frame("8n1", n0, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    chk("8n1.busy", bus.rx_busy_o, 1'b0);

    // 5 data bits, even parity, 2 stop: 0x13 has odd ones -> parity bit 1
    bus.rx_conf_i = 5'b00011;
    n0 = nvalid;
    send_frame(8'h13, 5, 1, 1, 2, 0);
    line(1'b0, 20);
    chk_frame("5p2.ok", n0, 8'h13, 1'b0, 1'b0);
    n0 = nvalid;
    send_frame(8'h13, 5, 1, 0, 2, 0);
    line(1'b0, 20);
    chk_frame("5p2.bad", n0, 8'h13, 1'b1, 1'b0);

    // Framing error then clean frame
    bus.rx_conf_i = 5'b11000;
    n0 = nvalid;
    send_frame(8'h3C, 8, 0, 0, 1, 1);
    line(1'b0, 24);
    chk_frame("ferr", n0, 8'h3C, 1'b0, 1'b1);
    n0 = nvalid;
    send_frame(8'h42, 8, 0, 0, 1, 0);
    line(1'b0, 20);
    chk_frame("clean", n0, 8'h42, 1'b0, 1'b0);

    // Glitch: 4-tick pulse must be rejected, then a normal frame still lands
    n0 = nvalid;
    busy_seen = 1'b0;
    line(1'b1, 4);
    line(1'b0, 24);
    chk("glitch.cnt", nvalid - n0, 0);
    chk("glitch.busy", busy_seen, 1'b0);
    n0 = nvalid;
    send_frame(8'h5A, 8, 0, 0, 1, 0);
    line(1'b0, 20);
    chk_frame("postglitch", n0, 8'h5A, 1'b0, 1'b0);

    // Abort after 3 data bits
    n0 = nvalid;
    line(1'b1, 16);
    line(1'b1, 16);
    line(1'b0, 16);
    line(1'b1, 16);
    @(negedge clk);
    chk("abort.busy_before", bus.rx_busy_o, 1'b1);
    bus.rx_en_i = 1'b0;
    ticks(1);
    @(negedge clk);
    chk("abort.busy_after", bus.rx_busy_o, 1'b0);
    line(1'b0, 120);
    chk("abort.cnt", nvalid - n0, 0);
    bus.rx_en_i = 1'b1;
    ticks(4);
    n0 = nvalid;
    send_frame(8'hFF, 8, 0, 0, 1, 0);
    line(1'b0, 20);
    chk_frame("reen", n0, 8'hFF, 1'b0, 1'b0);

    // Reset mid-frame clears outputs immediately
    line(1'b1, 16);
    line(1'b1, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.data", bus.rx_data_o, 8'h00);
    chk("midrst.busy", bus.rx_busy_o, 1'b0);
    chk("midrst.flags", {bus.rx_valid_o, bus.rx_parity_err_o, bus.rx_frame_err_o}, 3'b000);
    bus.uart_rx_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    ticks(40);

    // Back-to-back 8N1 frames with no idle gap
    n0 = nvalid;
    send_frame(8'h00, 8, 0, 0, 1, 0);
    send_frame(8'hFF, 8, 0, 0, 1, 0);
    line(1'b0, 20);
    chk("b2b.cnt", nvalid - n0, 2);
    if (nvalid >= n0 + 2) begin
      chk("b2b.d0", cap_data[n0], 8'h00);
      chk("b2b.d1", cap_data[n0+1], 8'hFF);
      chk("b2b.errs", {cap_perr[n0], cap_ferr[n0], cap_perr[n0+1], cap_ferr[n0+1]}, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
